// File: rtl/fpu_seq_ctrl_if.sv
// Decode / FPU / FP-regfile signal bundle for the FPU sequencing controller.
// slave = controller side, master = decode/environment side.
interface fpu_seq_ctrl_if;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic [4:0]  issue_fd;
  logic [4:0]  issue_fs;
  logic [4:0]  issue_ft;
  logic        issue_ready;
  logic        chk_valid;
  logic [4:0]  chk_reg;
  logic        fpld_valid;
  logic [4:0]  fpld_reg;
  logic [31:0] fpld_data;
  logic        fpu_start;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall;
  logic        err_illegal;

  modport slave (
    input  issue_valid, issue_op, issue_fd, issue_fs, issue_ft,
    input  chk_valid, chk_reg, fpld_valid, fpld_reg, fpld_data, fpu_result,
    output issue_ready, fpu_start, fpu_op, rf_we, rf_waddr, rf_wdata,
    output stall, err_illegal
  );

  modport master (
    output issue_valid, issue_op, issue_fd, issue_fs, issue_ft,
    output chk_valid, chk_reg, fpld_valid, fpld_reg, fpld_data, fpu_result,
    input  issue_ready, fpu_start, fpu_op, rf_we, rf_waddr, rf_wdata,
    input  stall, err_illegal
  );
endinterface

// File: rtl/fpu_seq_ctrl.sv
// Multi-cycle FPU issue/sequencing controller with FP regfile write-port arbitration.
// Optional build macro FPU_PERF_CNT_EN adds saturating busy/stall cycle counters.
//
// state | meaning
// IDLE  | ready for a new F-type op
// BUSY  | FPU computing, latency counter running down
// WB    | result waiting for the write port (FP loads have priority)
module fpu_seq_ctrl #(
  parameter int ADDSUB_LAT = 2,
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 12,
  parameter int UNARY_LAT  = 1,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  fpu_seq_ctrl_if.slave      bus
`ifdef FPU_PERF_CNT_EN
  ,
  output logic [15:0]        o_perf_busy_cyc,
  output logic [15:0]        o_perf_stall_cyc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_WB} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [4:0]         r_dest;
  logic [3:0]         r_op;
  logic               r_start;
  logic               r_err;

  logic               w_legal, w_binary, w_accept, w_busy;
  logic               w_ld_waw, w_ld_wr, w_fpu_wr;
  logic               w_rf_we;
  logic [4:0]         w_rf_waddr;
  logic [31:0]        w_rf_wdata;
  logic               w_stall;

  function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: lat_of = CNT_W'(ADDSUB_LAT - 1);
      4'd2:       lat_of = CNT_W'(MUL_LAT - 1);
      4'd3:       lat_of = CNT_W'(DIV_LAT - 1);
      default:    lat_of = CNT_W'(UNARY_LAT - 1);
    endcase
  endfunction

  assign w_legal  = (bus.issue_op <= 4'd5);
  assign w_binary = (bus.issue_op <= 4'd3);
  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = (r_state == S_IDLE) & bus.issue_valid & w_legal;

  // A load to the pending destination is held upstream (WAW), so it never
  // takes the port; the FPU result is granted whenever no load is writing.
  assign w_ld_waw = bus.fpld_valid & w_busy & (bus.fpld_reg == r_dest);
  assign w_ld_wr  = bus.fpld_valid & ~w_ld_waw;
  assign w_fpu_wr = (r_state == S_WB) & ~w_ld_wr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rf_we     = 1'b0;
    w_rf_waddr  = 5'd0;
    w_rf_wdata  = 32'd0;
    w_stall     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = lat_of(bus.issue_op);
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_WB;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_WB: begin
        if (w_fpu_wr) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_ld_wr) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = bus.fpld_reg;
      w_rf_wdata = bus.fpld_data;
    end else if (w_fpu_wr) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = r_dest;
      w_rf_wdata = bus.fpu_result;
    end

    w_stall = (bus.issue_valid & w_busy)
            | (bus.issue_valid & w_busy &
               ((bus.issue_fs == r_dest) | (w_binary & (bus.issue_ft == r_dest))))
            | (bus.chk_valid & w_busy & (bus.chk_reg == r_dest))
            | w_ld_waw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dest  <= 5'd0;
      r_op    <= 4'd0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= w_accept;
      r_err   <= (r_state == S_IDLE) & bus.issue_valid & ~w_legal;
      if (w_accept) begin
        r_dest <= bus.issue_fd;
        r_op   <= bus.issue_op;
      end
    end
  end

  assign bus.issue_ready = (r_state == S_IDLE);
  assign bus.fpu_start   = r_start;
  assign bus.fpu_op      = r_op;
  assign bus.rf_we       = w_rf_we;
  assign bus.rf_waddr    = w_rf_waddr;
  assign bus.rf_wdata    = w_rf_wdata;
  assign bus.stall       = w_stall;
  assign bus.err_illegal = r_err;

`ifdef FPU_PERF_CNT_EN
  logic [15:0] r_perf_busy, r_perf_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_busy  <= 16'd0;
      r_perf_stall <= 16'd0;
    end else begin
      if (w_busy & ~&r_perf_busy)   r_perf_busy  <= r_perf_busy + 16'd1;
      if (w_stall & ~&r_perf_stall) r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign o_perf_busy_cyc  = r_perf_busy;
  assign o_perf_stall_cyc = r_perf_stall;
`endif

endmodule
